// File: rtl/mem_arb_pkg.sv
// Shared encodings for the fetch / load-store memory port arbiter:
// func3 access codes, arbiter FSM states and grant owners.
package mem_arb_pkg;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  localparam logic [2:0] SB  = 3'b000;
  localparam logic [2:0] SH  = 3'b001;
  localparam logic [2:0] SW  = 3'b010;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_e;

  typedef enum logic {
    GRANT_IF = 1'b0,
    GRANT_D  = 1'b1
  } grant_e;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Signal bundle joining the fetch requester, the load/store requester and the
// shared memory to the arbiter; slave is the arbiter's view, master the environment's.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_valid;
  logic [31:0]       if_rdata;
  logic              d_rd;
  logic              d_wr;
  logic [2:0]        d_rw_type;
  logic [ADDR_W-1:0] d_addr;
  logic [31:0]       d_wdata;
  logic              d_valid;
  logic              d_err;
  logic [31:0]       d_rdata;
  logic              stall;
  logic              mem_en;
  logic [3:0]        mem_we;
  logic [ADDR_W-3:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  modport slave (
    input  if_req, if_addr, d_rd, d_wr, d_rw_type, d_addr, d_wdata, mem_rdata,
    output if_valid, if_rdata, d_valid, d_err, d_rdata, stall,
           mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output if_req, if_addr, d_rd, d_wr, d_rw_type, d_addr, d_wdata, mem_rdata,
    input  if_valid, if_rdata, d_valid, d_err, d_rdata, stall,
           mem_en, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/mem_lane_align.sv
// Combinational lane logic for the data path: store byte enables and lane
// replication, rejection of misaligned or illegal accesses, load extraction/extension.
module mem_lane_align
  import mem_arb_pkg::*;
(
  input  logic        rd_i,
  input  logic        wr_i,
  input  logic [2:0]  rw_type_i,
  input  logic [1:0]  offset_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  we_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o,
  output logic        err_o
);

  logic [7:0]  lane_byte;
  logic [15:0] lane_half;

  assign lane_byte = 8'(rdata_i >> {offset_i, 3'b000});
  assign lane_half = 16'(rdata_i >> {offset_i, 3'b000});

  // Store codes share values with the signed load codes, so wr_i picks the meaning.
  always_comb begin
    we_o    = 4'b0000;
    wdata_o = 32'h0;
    err_o   = 1'b0;
    case (rw_type_i)
      SB: begin
        we_o    = 4'b0001 << offset_i;
        wdata_o = {4{wdata_i[7:0]}};
      end
      SH: begin
        we_o    = 4'b0011 << offset_i;
        wdata_o = {2{wdata_i[15:0]}};
        err_o   = offset_i[0];
      end
      SW: begin
        we_o    = 4'b1111;
        wdata_o = wdata_i;
        err_o   = (offset_i != 2'b00);
      end
      LBU:     err_o = wr_i;
      LHU:     err_o = wr_i | offset_i[0];
      default: err_o = 1'b1;
    endcase
    if (rd_i && wr_i) begin
      err_o = 1'b1;
    end
    if (!wr_i) begin
      we_o    = 4'b0000;
      wdata_o = 32'h0;
    end
  end

  always_comb begin
    rdata_o = 32'h0;
    case (rw_type_i)
      LB:      rdata_o = {{24{lane_byte[7]}}, lane_byte};
      LH:      rdata_o = {{16{lane_half[15]}}, lane_half};
      LW:      rdata_o = rdata_i;
      LBU:     rdata_o = {24'h0, lane_byte};
      LHU:     rdata_o = {16'h0, lane_half};
      default: rdata_o = 32'h0;
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one fixed-latency word memory between instruction
// fetch and the load/store path; all responses and memory strobes are registered.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int MEM_LAT = 1
) (
  input logic               clk,
  input logic               rst_n,
  mem_port_arbiter_if.slave bus
);

  state_e            state_q, state_d;
  grant_e            grant_q, grant_d;
  grant_e            last_grant_q, last_grant_d;
  logic [2:0]        lat_cnt_q, lat_cnt_d;
  logic              if_valid_q, if_valid_d;
  logic [31:0]       if_rdata_q, if_rdata_d;
  logic              d_valid_q, d_valid_d;
  logic              d_err_q, d_err_d;
  logic [31:0]       d_rdata_q, d_rdata_d;
  logic              mem_en_q, mem_en_d;
  logic [3:0]        mem_we_q, mem_we_d;
  logic [ADDR_W-3:0] mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;

  logic        d_req;
  logic [3:0]  lane_we;
  logic [31:0] lane_wdata;
  logic [31:0] lane_rdata;
  logic        lane_err;
  logic        unused_if_offset;

  assign d_req            = bus.d_rd | bus.d_wr;
  assign unused_if_offset = ^bus.if_addr[1:0];

  mem_lane_align u_align (
    .rd_i     (bus.d_rd),
    .wr_i     (bus.d_wr),
    .rw_type_i(bus.d_rw_type),
    .offset_i (bus.d_addr[1:0]),
    .wdata_i  (bus.d_wdata),
    .rdata_i  (bus.mem_rdata),
    .we_o     (lane_we),
    .wdata_o  (lane_wdata),
    .rdata_o  (lane_rdata),
    .err_o    (lane_err)
  );

  // Request inputs stay stable until their valid pulse, so later states read them live.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    lat_cnt_d    = lat_cnt_q;
    if_valid_d   = 1'b0;
    if_rdata_d   = 32'h0;
    d_valid_d    = 1'b0;
    d_err_d      = 1'b0;
    d_rdata_d    = 32'h0;
    mem_en_d     = 1'b0;
    mem_we_d     = 4'b0000;
    mem_addr_d   = '0;
    mem_wdata_d  = 32'h0;
    case (state_q)
      IDLE: begin
        if (bus.if_req || d_req) begin
          if (bus.if_req && d_req) begin
            grant_d = (last_grant_q == GRANT_IF) ? GRANT_D : GRANT_IF;
          end else begin
            grant_d = bus.if_req ? GRANT_IF : GRANT_D;
          end
          last_grant_d = grant_d;
          if (grant_d == GRANT_D && lane_err) begin
            state_d   = RESP;
            d_valid_d = 1'b1;
            d_err_d   = 1'b1;
          end else begin
            state_d     = ISSUE;
            mem_en_d    = 1'b1;
            mem_addr_d  = (grant_d == GRANT_IF) ? bus.if_addr[ADDR_W-1:2]
                                                : bus.d_addr[ADDR_W-1:2];
            mem_we_d    = (grant_d == GRANT_D) ? lane_we : 4'b0000;
            mem_wdata_d = (grant_d == GRANT_D) ? lane_wdata : 32'h0;
          end
        end
      end
      ISSUE: begin
        if (grant_q == GRANT_D && bus.d_wr) begin
          state_d   = RESP;
          d_valid_d = 1'b1;
        end else begin
          state_d   = WAIT;
          lat_cnt_d = 3'd1;
        end
      end
      WAIT: begin
        if (lat_cnt_q == 3'(MEM_LAT)) begin
          state_d = RESP;
          if (grant_q == GRANT_IF) begin
            if_valid_d = 1'b1;
            if_rdata_d = bus.mem_rdata;
          end else begin
            d_valid_d = 1'b1;
            d_rdata_d = lane_rdata;
          end
        end else begin
          lat_cnt_d = lat_cnt_q + 3'd1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      grant_q      <= GRANT_IF;
      last_grant_q <= GRANT_IF;
      lat_cnt_q    <= 3'd0;
      if_valid_q   <= 1'b0;
      if_rdata_q   <= 32'h0;
      d_valid_q    <= 1'b0;
      d_err_q      <= 1'b0;
      d_rdata_q    <= 32'h0;
      mem_en_q     <= 1'b0;
      mem_we_q     <= 4'b0000;
      mem_addr_q   <= '0;
      mem_wdata_q  <= 32'h0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      lat_cnt_q    <= lat_cnt_d;
      if_valid_q   <= if_valid_d;
      if_rdata_q   <= if_rdata_d;
      d_valid_q    <= d_valid_d;
      d_err_q      <= d_err_d;
      d_rdata_q    <= d_rdata_d;
      mem_en_q     <= mem_en_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
    end
  end

  assign bus.if_valid  = if_valid_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.d_valid   = d_valid_q;
  assign bus.d_err     = d_err_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.mem_en    = mem_en_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;

  // Each requester stops stalling in the cycle its own valid pulse appears.
  assign bus.stall = rst_n & ((bus.if_req & ~if_valid_q) | (d_req & ~d_valid_q));

endmodule
